// File: rtl/iomem_uart_bridge.sv
// ---------------------------------------------------------------------------
// iomem_uart_bridge
//
// Byte-stream to iomem bus initiator. Parses commands from an 8-bit receive
// stream and performs one single-beat transfer on the iomem valid/ready bus,
// then reports the result on an 8-bit transmit stream.
//
//   'W' (0x57) + addr[4] + data[4]  -> write, response 'K' (0x4B)
//   'R' (0x52) + addr[4]            -> read,  response rdata[7:0]..rdata[31:24]
//   any other opcode                -> response '?' (0x3F), no bus cycle
//   bus timeout (optional)          -> response 'T' (0x54), no data bytes
// Multi-byte fields are little-endian (first byte carries bits 7:0).
//
// Ports:
//   clk, resetn         clock, synchronous active-low reset
//   rx_data/valid/ready command byte stream in (handshake on valid && ready)
//   tx_data/valid/ready response byte stream out (data held until ready)
//   iomem_valid/ready   bus request / one-cycle completion pulse
//   iomem_wstrb         4'hF for writes, 4'h0 for reads
//   iomem_addr/wdata    transfer address / write data, stable while valid
//   iomem_rdata         read data, captured on the iomem_ready edge
//   busy                high whenever the bridge is not idle
//
// Configuration macro: IOMEM_BRIDGE_TIMEOUT_EN
//   Defined   : parameter TIMEOUT_CYCLES (default 1024, >= 2) bounds how many
//               cycles iomem_valid may stay high without iomem_ready; on
//               expiry the request is withdrawn and 'T' is returned.
//   Undefined : no timeout logic and no TIMEOUT_CYCLES parameter; the bus
//               state waits for iomem_ready indefinitely.
// ---------------------------------------------------------------------------
module iomem_uart_bridge
`ifdef IOMEM_BRIDGE_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 1024
)
`endif
(
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        iomem_valid,
    input  logic        iomem_ready,
    output logic [3:0]  iomem_wstrb,
    output logic [31:0] iomem_addr,
    output logic [31:0] iomem_wdata,
    input  logic [31:0] iomem_rdata,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_BUS,
        ST_RESP
    } state_t;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RSP_OK   = 8'h4B;
    localparam logic [7:0] RSP_UNK  = 8'h3F;
`ifdef IOMEM_BRIDGE_TIMEOUT_EN
    localparam logic [7:0] RSP_TMO  = 8'h54;
    localparam int         TW       = $clog2(TIMEOUT_CYCLES);
`endif

    state_t      state_reg;
    logic [1:0]  cnt_reg;       // byte index within ADDR / DATA / RESP
    logic        is_write_reg;
    logic        multi_reg;     // response is the four rdata bytes
    logic [31:0] rdata_reg;
`ifdef IOMEM_BRIDGE_TIMEOUT_EN
    logic [TW-1:0] tmo_reg;     // cycles spent with iomem_valid high
`endif

    logic rx_fire;
    logic tx_fire;

    assign rx_fire = rx_valid && rx_ready;
    assign tx_fire = tx_valid && tx_ready;

    // Byte lanes of the captured read data, indexed by response byte number.
    logic [7:0] rdata_lane [4];
    logic [1:0] next_cnt;

    assign next_cnt = cnt_reg + 2'd1;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rdata_lane
            assign rdata_lane[gi] = rdata_reg[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= 2'd0;
            is_write_reg <= 1'b0;
            multi_reg    <= 1'b0;
            rdata_reg    <= 32'd0;
            rx_ready     <= 1'b0;
            tx_data      <= 8'd0;
            tx_valid     <= 1'b0;
            iomem_valid  <= 1'b0;
            iomem_wstrb  <= 4'h0;
            iomem_addr   <= 32'd0;
            iomem_wdata  <= 32'd0;
            busy         <= 1'b0;
`ifdef IOMEM_BRIDGE_TIMEOUT_EN
            tmo_reg      <= '0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // Also raises rx_ready on the first cycle out of reset.
                    rx_ready <= 1'b1;
                    if (rx_fire) begin
                        cnt_reg <= 2'd0;
                        busy    <= 1'b1;
                        if (rx_data == OP_WRITE || rx_data == OP_READ) begin
                            is_write_reg <= (rx_data == OP_WRITE);
                            state_reg    <= ST_ADDR;
                        end else begin
                            state_reg <= ST_RESP;
                            rx_ready  <= 1'b0;
                            tx_valid  <= 1'b1;
                            tx_data   <= RSP_UNK;
                            multi_reg <= 1'b0;
                        end
                    end
                end

                ST_ADDR: begin
                    if (rx_fire) begin
                        // Address is assembled in place; it is not driven
                        // onto the bus until iomem_valid rises.
                        iomem_addr[{cnt_reg, 3'b000} +: 8] <= rx_data;
                        cnt_reg <= next_cnt;
                        if (cnt_reg == 2'd3) begin
                            cnt_reg <= 2'd0;
                            if (is_write_reg) begin
                                state_reg <= ST_DATA;
                            end else begin
                                state_reg   <= ST_BUS;
                                rx_ready    <= 1'b0;
                                iomem_valid <= 1'b1;
                                iomem_wstrb <= 4'h0;
`ifdef IOMEM_BRIDGE_TIMEOUT_EN
                                tmo_reg     <= '0;
`endif
                            end
                        end
                    end
                end

                ST_DATA: begin
                    if (rx_fire) begin
                        iomem_wdata[{cnt_reg, 3'b000} +: 8] <= rx_data;
                        cnt_reg <= next_cnt;
                        if (cnt_reg == 2'd3) begin
                            cnt_reg     <= 2'd0;
                            state_reg   <= ST_BUS;
                            rx_ready    <= 1'b0;
                            iomem_valid <= 1'b1;
                            iomem_wstrb <= 4'hF;
`ifdef IOMEM_BRIDGE_TIMEOUT_EN
                            tmo_reg     <= '0;
`endif
                        end
                    end
                end

                ST_BUS: begin
                    // Completion has priority, so a ready on the terminal
                    // timeout cycle still counts as success.
                    if (iomem_ready) begin
                        iomem_valid <= 1'b0;
                        iomem_wstrb <= 4'h0;
                        rdata_reg   <= iomem_rdata;
                        state_reg   <= ST_RESP;
                        cnt_reg     <= 2'd0;
                        tx_valid    <= 1'b1;
                        multi_reg   <= !is_write_reg;
                        tx_data     <= is_write_reg ? RSP_OK : iomem_rdata[7:0];
                    end
`ifdef IOMEM_BRIDGE_TIMEOUT_EN
                    else if (tmo_reg == TW'(TIMEOUT_CYCLES - 1)) begin
                        iomem_valid <= 1'b0;
                        iomem_wstrb <= 4'h0;
                        state_reg   <= ST_RESP;
                        cnt_reg     <= 2'd0;
                        tx_valid    <= 1'b1;
                        multi_reg   <= 1'b0;
                        tx_data     <= RSP_TMO;
                    end else begin
                        tmo_reg <= tmo_reg + TW'(1);
                    end
`endif
                end

                ST_RESP: begin
                    if (tx_fire) begin
                        if (!multi_reg || cnt_reg == 2'd3) begin
                            tx_valid  <= 1'b0;
                            state_reg <= ST_IDLE;
                            cnt_reg   <= 2'd0;
                            busy      <= 1'b0;
                            rx_ready  <= 1'b1;
                        end else begin
                            cnt_reg <= next_cnt;
                            tx_data <= rdata_lane[next_cnt];
                        end
                    end
                end

                default: begin
                    state_reg   <= ST_IDLE;
                    cnt_reg     <= 2'd0;
                    rx_ready    <= 1'b0;
                    tx_valid    <= 1'b0;
                    iomem_valid <= 1'b0;
                    iomem_wstrb <= 4'h0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iomem_uart_bridge.sv
// ---------------------------------------------------------------------------
// tb_iomem_uart_bridge
//
// Self-checking bench for iomem_uart_bridge. Expected bus transfers and
// response bytes are pushed to queues when a command is sent; a responder
// model pops/compares bus transfers and a transmit sink pops/compares
// response bytes. All DUT outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_iomem_uart_bridge;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        iomem_valid;
    logic        iomem_ready = 1'b0;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata = 32'd0;
    logic        busy;

    always #5 clk = ~clk;

`ifdef IOMEM_BRIDGE_TIMEOUT_EN
    iomem_uart_bridge #(.TIMEOUT_CYCLES(16)) dut (
`else
    iomem_uart_bridge dut (
`endif
        .clk(clk), .resetn(resetn),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
        .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
        .busy(busy)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } bus_t;

    bus_t       bus_q[$];
    logic [7:0] tx_q[$];
    bus_t       bus_exp;
    logic [7:0] tx_exp;

    bit          resp_en = 1'b1;
    int          resp_delay = 0;
    logic [31:0] resp_rdata = 32'd0;
    int          wait_cnt = 0;
    int          valid_cycles = 0;
    bit          tx_toggle = 1'b0;
    bit          tx_phase = 1'b0;

    // Responder: raises iomem_ready for one cycle after resp_delay cycles.
    always @(negedge clk) begin
        iomem_ready = 1'b0;
        if (iomem_valid) begin
            valid_cycles++;
            if (resp_en && wait_cnt >= resp_delay) begin
                iomem_ready = 1'b1;
                iomem_rdata = resp_rdata;
                wait_cnt = 0;
                checks++;
                if (bus_q.size() == 0) begin
                    failures++;
                    $display("FAIL bus_unexpected: got addr=%h wstrb=%h, required no transfer",
                             iomem_addr, iomem_wstrb);
                end else begin
                    bus_exp = bus_q.pop_front();
                    if (iomem_addr !== bus_exp.addr || iomem_wstrb !== bus_exp.wstrb ||
                        (bus_exp.wstrb == 4'hF && iomem_wdata !== bus_exp.wdata)) begin
                        failures++;
                        $display("FAIL bus_xfer: got addr=%h wdata=%h wstrb=%h, required addr=%h wdata=%h wstrb=%h",
                                 iomem_addr, iomem_wdata, iomem_wstrb,
                                 bus_exp.addr, bus_exp.wdata, bus_exp.wstrb);
                    end
                end
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // Transmit sink: tx_ready is set first so the check sees the value the
    // DUT will sample on the next rising edge.
    always @(negedge clk) begin
        if (tx_toggle) begin
            tx_phase = ~tx_phase;
            tx_ready = tx_phase;
        end else begin
            tx_ready = 1'b1;
        end
        if (tx_valid && tx_ready) begin
            checks++;
            if (tx_q.size() == 0) begin
                failures++;
                $display("FAIL tx_unexpected: got %h, required no byte", tx_data);
            end else begin
                tx_exp = tx_q.pop_front();
                if (tx_data !== tx_exp) begin
                    failures++;
                    $display("FAIL tx_byte: got %h, required %h", tx_data, tx_exp);
                end
                $display("tx byte %h (expected %h)", tx_data, tx_exp);
            end
        end
    end

    // No command bytes may be accepted while a transfer or response is open.
    always @(negedge clk) begin
        if (resetn && (tx_valid || iomem_valid)) begin
            checks++;
            if (rx_ready !== 1'b0) begin
                failures++;
                $display("FAIL rx_ready_busy: got %b, required 0", rx_ready);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++;
            failures++;
            $display("FAIL rx_stall: byte %h not accepted in 300 cycles, required acceptance", b);
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_write(input logic [31:0] a, input logic [31:0] d);
        send_byte(8'h57);
        for (int i = 0; i < 4; i++) send_byte(a[i*8 +: 8]);
        for (int i = 0; i < 4; i++) send_byte(d[i*8 +: 8]);
    endtask

    task automatic send_read(input logic [31:0] a);
        send_byte(8'h52);
        for (int i = 0; i < 4; i++) send_byte(a[i*8 +: 8]);
    endtask

    task automatic push_bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bus_t t;
        t.addr = a; t.wdata = d; t.wstrb = s;
        bus_q.push_back(t);
    endtask

    task automatic push_read_resp(input logic [31:0] d);
        for (int i = 0; i < 4; i++) tx_q.push_back(d[i*8 +: 8]);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((tx_q.size() != 0 || bus_q.size() != 0 || busy !== 1'b0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 500) begin
            failures++;
            $display("FAIL %s_drain: got pending tx=%0d bus=%0d busy=%b, required all empty and idle",
                     name, tx_q.size(), bus_q.size(), busy);
        end
    endtask

    task automatic do_reset_check(input string name);
        @(negedge clk);
        rx_valid = 1'b0;
        resetn   = 1'b0;
        @(negedge clk);
        checks++;
        if (rx_ready !== 1'b0 || tx_valid !== 1'b0 || tx_data !== 8'd0 ||
            iomem_valid !== 1'b0 || iomem_wstrb !== 4'h0 || iomem_addr !== 32'd0 ||
            iomem_wdata !== 32'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_values: got rx_ready=%b tx_valid=%b tx_data=%h valid=%b wstrb=%h addr=%h wdata=%h busy=%b, required all 0",
                     name, rx_ready, tx_valid, tx_data, iomem_valid, iomem_wstrb,
                     iomem_addr, iomem_wdata, busy);
        end
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_rx_ready: got %b, required 1", name, rx_ready);
        end
        $display("reset %s done", name);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        do_reset_check("initial_reset");
    endtask

    task automatic test_write();
        resp_en = 1'b1; resp_delay = 1; valid_cycles = 0;
        push_bus(32'h0300_0000, 32'h0000_00A5, 4'hF);
        tx_q.push_back(8'h4B);
        send_write(32'h0300_0000, 32'h0000_00A5);
        checks++;
        if (iomem_valid !== 1'b1) begin
            failures++;
            $display("FAIL write_valid_rise: got %b, required 1", iomem_valid);
        end
        wait_idle("write");
        checks++;
        if (valid_cycles != 2) begin
            failures++;
            $display("FAIL write_valid_len: got %0d, required 2", valid_cycles);
        end
        $display("write addr=03000000 data=000000a5 done");
    endtask

    task automatic test_read();
        resp_en = 1'b1; resp_delay = 0; valid_cycles = 0;
        resp_rdata = 32'h1234_5678;
        push_bus(32'h0300_0000, 32'h0, 4'h0);
        push_read_resp(32'h1234_5678);
        send_read(32'h0300_0000);
        wait_idle("read");
        checks++;
        if (valid_cycles != 1) begin
            failures++;
            $display("FAIL read_valid_len: got %0d, required 1", valid_cycles);
        end
        $display("read addr=03000000 rdata=12345678 done");
    endtask

    task automatic test_back_to_back();
        resp_en = 1'b1; resp_delay = 2;
        resp_rdata = 32'hA1B2_C3D4;
        tx_toggle = 1'b1;
        push_bus(32'h0300_0010, 32'hCAFE_F00D, 4'hF);
        tx_q.push_back(8'h4B);
        push_bus(32'h0300_0020, 32'h0, 4'h0);
        push_read_resp(32'hA1B2_C3D4);
        send_write(32'h0300_0010, 32'hCAFE_F00D);
        send_read(32'h0300_0020);
        wait_idle("back_to_back");
        tx_toggle = 1'b0;
        $display("back-to-back write+read done");
    endtask

    task automatic test_unknown();
        resp_en = 1'b1; resp_delay = 0;
        valid_cycles = 0;
        tx_q.push_back(8'h3F);
        send_byte(8'h41);
        wait_idle("unknown");
        checks++;
        if (valid_cycles != 0) begin
            failures++;
            $display("FAIL unknown_no_bus: got %0d valid cycles, required 0", valid_cycles);
        end
        resp_rdata = 32'hDEAD_BEEF;
        push_bus(32'h0300_0106, 32'h0, 4'h0);
        push_read_resp(32'hDEAD_BEEF);
        send_read(32'h0300_0106);
        wait_idle("after_unknown");
        $display("unknown opcode 41 then read done");
    endtask

    task automatic test_timeout();
        resp_en = 1'b0; valid_cycles = 0;
`ifdef IOMEM_BRIDGE_TIMEOUT_EN
        tx_q.push_back(8'h54);
        send_read(32'h0300_0040);
        wait_idle("timeout");
        checks++;
        if (valid_cycles != 16) begin
            failures++;
            $display("FAIL timeout_valid_len: got %0d, required 16", valid_cycles);
        end
`else
        send_read(32'h0300_0040);
        repeat (1100) @(negedge clk);
        checks++;
        if (iomem_valid !== 1'b1 || valid_cycles < 1000 || iomem_addr !== 32'h0300_0040) begin
            failures++;
            $display("FAIL no_timeout_hold: got valid=%b cycles=%0d addr=%h, required valid=1 cycles>=1000 addr=03000040",
                     iomem_valid, valid_cycles, iomem_addr);
        end
        do_reset_check("after_hang");
`endif
        resp_en = 1'b1;
        $display("timeout scenario done (%0d valid cycles)", valid_cycles);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        // Abort in the middle of the address field.
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h00);
        do_reset_check("mid_addr");
        resp_en = 1'b1; resp_delay = 0;
        push_bus(32'h0300_0008, 32'h5A5A_1234, 4'hF);
        tx_q.push_back(8'h4B);
        send_write(32'h0300_0008, 32'h5A5A_1234);
        wait_idle("after_mid_addr");
        // Abort while the bus request is outstanding.
        resp_en = 1'b0;
        send_read(32'h0300_00F0);
        while (iomem_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        do_reset_check("mid_bus");
        resp_en = 1'b1;
        resp_rdata = 32'h0BAD_F00D;
        push_bus(32'h0300_00F4, 32'h0, 4'h0);
        push_read_resp(32'h0BAD_F00D);
        send_read(32'h0300_00F4);
        wait_idle("after_mid_bus");
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_unknown();
        test_timeout();
        test_reset_mid();
        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
